// File: rtl/fetch_queue.sv
// Instruction fetch queue: pairs each issued PC with the memory data returned one
// cycle later and buffers the pairs for decode, back-pressuring the PC register.
module fetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [31:0]              pc_f,
    input  logic [31:0]              instr_rdata,
    input  logic                     flush,
    input  logic                     deq,
    output logic                     stall_f,
    output logic                     valid_d,
    output logic [31:0]              pc_d,
    output logic [31:0]              instr_d,
    output logic                     misaligned_d,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          req_pending_q, req_pending_d;
    logic [31:0]   req_pc_q, req_pc_d;
    logic          req_mis_q, req_mis_d;

    logic [31:0]   pc_mem    [DEPTH];
    logic [31:0]   instr_mem [DEPTH];
    logic          mis_mem   [DEPTH];

    logic [CW:0]   occupancy;
    logic          issue;
    logic          enq;
    logic          do_deq;

    // Reserve a slot for the in-flight fetch; a same-cycle deq earns no credit,
    // so an enqueue can never find the queue full.
    assign occupancy = {1'b0, count_q} + {{CW{1'b0}}, req_pending_q};
    assign stall_f   = (occupancy >= (CW+1)'(DEPTH));

    assign issue  = !stall_f && !flush;
    assign enq    = req_pending_q && !flush;
    assign do_deq = deq && (count_q != '0) && !flush;

    always_comb begin
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        req_pending_d = 1'b0;
        req_pc_d      = req_pc_q;
        req_mis_d     = req_mis_q;

        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (enq) begin
                tail_d = tail_q + AW'(1);
            end
            if (do_deq) begin
                head_d = head_q + AW'(1);
            end
            if (enq && !do_deq) begin
                count_d = count_q + CW'(1);
            end else if (!enq && do_deq) begin
                count_d = count_q - CW'(1);
            end
        end

        if (issue) begin
            req_pending_d = 1'b1;
            req_pc_d      = pc_f;
            req_mis_d     = (pc_f[1:0] != 2'b00);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            req_pending_q <= 1'b0;
            req_pc_q      <= '0;
            req_mis_q     <= 1'b0;
        end else begin
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            req_pending_q <= req_pending_d;
            req_pc_q      <= req_pc_d;
            req_mis_q     <= req_mis_d;
        end
    end

    // Storage needs no reset: entries are only visible through count_q.
    always_ff @(posedge clk) begin
        if (!reset && enq) begin
            pc_mem[tail_q]    <= req_pc_q;
            instr_mem[tail_q] <= instr_rdata;
            mis_mem[tail_q]   <= req_mis_q;
        end
    end

    assign valid_d      = (count_q != '0);
    assign pc_d         = valid_d ? pc_mem[head_q]    : 32'h0;
    assign instr_d      = valid_d ? instr_mem[head_q] : 32'h0;
    assign misaligned_d = valid_d ? mis_mem[head_q]   : 1'b0;
    assign count        = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: queue-based reference model with a PC register and
// synchronous memory model, directed scenarios plus randomized traffic.
module tb_fetch_queue;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          flush = 1'b0;
    logic          deq = 1'b0;
    logic [31:0]   pc_f = 32'h0;
    logic [31:0]   instr_rdata = 32'h0;
    logic          stall_f;
    logic          valid_d;
    logic [31:0]   pc_d;
    logic [31:0]   instr_d;
    logic          misaligned_d;
    logic [CW-1:0] count;

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .pc_f         (pc_f),
        .instr_rdata  (instr_rdata),
        .flush        (flush),
        .deq          (deq),
        .stall_f      (stall_f),
        .valid_d      (valid_d),
        .pc_d         (pc_d),
        .instr_d      (instr_d),
        .misaligned_d (misaligned_d),
        .count        (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        mis;
    } ent_t;

    ent_t        q[$];
    bit          pend = 1'b0;
    logic [31:0] pend_pc = 32'h0;
    bit          pend_mis = 1'b0;
    logic [31:0] pc_cur = 32'h0;
    logic [31:0] last_pc = 32'h0;
    logic [31:0] step = 32'd4;
    bit          known = 1'b0;
    int          n_chk = 0;
    int          n_fail = 0;

    // Memory contents: an addi-like word derived from the word address.
    function automatic logic [31:0] mem(input logic [31:0] a);
        logic [31:0] k;
        k = a >> 2;
        return (k << 20) | ((k & 32'h1f) << 7) | 32'h13;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: compare current outputs with the model, apply inputs,
    // then advance the model to the state after the coming edge.
    task automatic cycle(input bit r, input bit f, input bit d, input logic [31:0] tgt);
        bit stall_m;
        @(negedge clk);
        if (known) begin
            chk("stall_f", 32'(stall_f), 32'((q.size() + int'(pend)) >= DEPTH));
            chk("valid_d", 32'(valid_d), 32'(q.size() != 0));
            chk("count",   32'(count),   32'(q.size()));
            chk("pc_d",    pc_d,    (q.size() != 0) ? q[0].pc    : 32'h0);
            chk("instr_d", instr_d, (q.size() != 0) ? q[0].instr : 32'h0);
            chk("mis_d",   32'(misaligned_d), (q.size() != 0) ? 32'(q[0].mis) : 32'h0);
        end
        stall_m     = (q.size() + int'(pend)) >= DEPTH;
        reset       = r;
        flush       = f;
        deq         = d;
        pc_f        = pc_cur;
        instr_rdata = mem(last_pc);
        last_pc     = pc_cur;
        if (r) begin
            q.delete();
            pend   = 1'b0;
            pc_cur = 32'h0;
            known  = 1'b1;
        end else if (f) begin
            q.delete();
            pend   = 1'b0;
            pc_cur = tgt;
        end else begin
            if (d && q.size() > 0) void'(q.pop_front());
            if (pend) q.push_back('{pend_pc, instr_rdata, pend_mis});
            if (!stall_m) begin
                pend     = 1'b1;
                pend_pc  = pc_f;
                pend_mis = (pc_f[1:0] != 2'b00);
                pc_cur   = pc_cur + step;
            end else begin
                pend = 1'b0;
            end
        end
    endtask

    initial begin
        // Streaming with deq held high
        cycle(1, 0, 0, 0);
        cycle(0, 0, 1, 0); chk("stream_valid_rel", 32'(valid_d), 0);
        cycle(0, 0, 1, 0); chk("stream_valid_rel1", 32'(valid_d), 0);
        cycle(0, 0, 1, 0);
        chk("stream_valid_rel2", 32'(valid_d), 1);
        chk("stream_pc0", pc_d, 32'h0);
        chk("stream_in0", instr_d, 32'h00000013);
        cycle(0, 0, 1, 0);
        chk("stream_pc1", pc_d, 32'h4);
        chk("stream_in1", instr_d, 32'h00100093);
        cycle(0, 0, 1, 0);
        chk("stream_pc2", pc_d, 32'h8);
        chk("stream_in2", instr_d, 32'h00200113);
        chk("stream_stall", 32'(stall_f), 0);

        // Fill to full with deq low
        cycle(1, 0, 0, 0);
        repeat (4) cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        chk("fill_stall_rise", 32'(stall_f), 1);
        chk("fill_count3", 32'(count), 3);
        cycle(0, 0, 0, 0);
        chk("fill_count4", 32'(count), 4);
        repeat (3) begin
            cycle(0, 0, 0, 0);
            chk("fill_hold4", 32'(count), 4);
            chk("fill_hold_stall", 32'(stall_f), 1);
        end
        cycle(0, 0, 1, 0);
        chk("fill_deq_stall", 32'(stall_f), 1);
        cycle(0, 0, 0, 0);
        chk("fill_after_deq_count", 32'(count), 3);
        chk("fill_stall_fall", 32'(stall_f), 0);

        // Flush with count=3 and a fetch in flight
        cycle(0, 1, 0, 32'h100);
        chk("flush_pre_count", 32'(count), 3);
        cycle(0, 0, 1, 0);
        chk("flush_count0", 32'(count), 0);
        chk("flush_valid0", 32'(valid_d), 0);
        cycle(0, 0, 1, 0);
        chk("flush_valid_l", 32'(valid_d), 0);
        cycle(0, 0, 1, 0);
        chk("flush_tgt_valid", 32'(valid_d), 1);
        chk("flush_tgt_pc", pc_d, 32'h100);
        chk("flush_tgt_in", instr_d, 32'h04000013);

        // Misaligned PC between aligned neighbours
        step = 32'd2;
        cycle(0, 1, 1, 32'h100);
        cycle(0, 0, 1, 0);
        cycle(0, 0, 1, 0);
        cycle(0, 0, 1, 0);
        chk("mis_pc0", pc_d, 32'h100);
        chk("mis_m0", 32'(misaligned_d), 0);
        cycle(0, 0, 1, 0);
        chk("mis_pc1", pc_d, 32'h102);
        chk("mis_m1", 32'(misaligned_d), 1);
        cycle(0, 0, 1, 0);
        chk("mis_pc2", pc_d, 32'h104);
        chk("mis_m2", 32'(misaligned_d), 0);
        step = 32'd4;

        // Wrap-around with deq toggling
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 26; i++) cycle(0, 0, i[0], 0);

        // Reset mid-operation with count=2 and a fetch pending
        cycle(1, 0, 0, 0);
        repeat (3) cycle(0, 0, 0, 0);
        cycle(1, 0, 0, 0);
        chk("rst_pre_count", 32'(count), 2);
        cycle(0, 0, 0, 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_valid", 32'(valid_d), 0);
        chk("rst_stall", 32'(stall_f), 0);
        chk("rst_pc", pc_d, 32'h0);
        chk("rst_instr", instr_d, 32'h0);
        chk("rst_mis", 32'(misaligned_d), 0);
        cycle(0, 0, 0, 0);
        chk("rst_valid1", 32'(valid_d), 0);
        cycle(0, 0, 0, 0);
        chk("rst_new_valid", 32'(valid_d), 1);
        chk("rst_new_pc", pc_d, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit          r;
            bit          f;
            bit          d;
            logic [31:0] t;
            r = ($urandom_range(0, 199) == 0);
            f = ($urandom_range(0, 15) == 0);
            d = ($urandom_range(0, 99) < 60);
            t = $urandom & 32'h0000_fffc;
            if ($urandom_range(0, 7) == 0) t = t | 32'h2;
            if ($urandom_range(0, 63) == 0) step = ($urandom_range(0, 3) == 0) ? 32'd2 : 32'd4;
            cycle(r, f, d, t);
        end
        cycle(0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
